// File: rtl/recip_float.sv
// recip_float: sequential reciprocal of a 16-bit float (1 sign, 8 exponent bias 127,
// 7 mantissa, implicit leading one). A normal operand runs a 9-step restoring
// division of 2^15 by the full significand, then one normalisation step.
// Zero/denormal operands return signed infinity with dz; inf/NaN return signed zero.
// Results below the normal range flush to signed zero with uf.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset
//   start_i   request pulse, sampled only while idle
//   a_i       operand, captured when start is accepted
//   result_o  reciprocal, valid with done_o, held until the next accepted start
//   busy_o    high from the edge after acceptance through the done cycle
//   done_o    one-cycle completion pulse
//   dz_o      divide-by-zero flag, held with result_o
//   uf_o      underflow (flush-to-zero) flag, held with result_o
module recip_float (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [15:0] a_i,
  output logic [15:0] result_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        dz_o,
  output logic        uf_o
);

  typedef enum logic [1:0] {StIdle, StDiv, StNorm, StDone} state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_q, exp_d;
  logic [7:0]  d_q, d_d;
  logic [8:0]  r_q, r_d;
  logic [8:0]  q_q, q_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic        dz_q, dz_d;
  logic        uf_q, uf_d;

  logic [7:0]  diff;
  logic [9:0]  exp_calc;

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    d_d      = d_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dz_d     = dz_q;
    uf_d     = uf_q;
    // Remainder stays below D (< 256) after a subtract, so 8 bits suffice.
    diff     = r_q[7:0] - d_q;
    // Q[8] set only for D == 128 (mantissa 0); otherwise Q[7] is the leading one.
    exp_calc = (q_q[8] ? 10'd254 : 10'd253) - {2'b00, exp_q};

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          sign_d = a_i[15];
          exp_d  = a_i[14:7];
          d_d    = {1'b1, a_i[6:0]};
          r_d    = 9'd128;
          q_d    = '0;
          cnt_d  = '0;
          dz_d   = 1'b0;
          uf_d   = 1'b0;
          if (a_i[14:7] == 8'h00) begin
            result_d = {a_i[15], 8'hFF, 7'h00};
            dz_d     = 1'b1;
            state_d  = StDone;
          end else if (a_i[14:7] == 8'hFF) begin
            result_d = {a_i[15], 15'b0};
            state_d  = StDone;
          end else begin
            state_d = StDiv;
          end
        end
      end
      StDiv: begin
        if (r_q >= {1'b0, d_q}) begin
          r_d = {diff, 1'b0};
          q_d = {q_q[7:0], 1'b1};
        end else begin
          r_d = {r_q[7:0], 1'b0};
          q_d = {q_q[7:0], 1'b0};
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd8) state_d = StNorm;
      end
      StNorm: begin
        if (exp_calc[9] || exp_calc == 10'd0) begin
          result_d = {sign_q, 15'b0};
          uf_d     = 1'b1;
        end else begin
          result_d = {sign_q, exp_calc[7:0], q_q[8] ? 7'h00 : q_q[6:0]};
        end
        state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      d_q      <= '0;
      r_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      d_q      <= d_d;
      r_q      <= r_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dz_q     <= dz_d;
      uf_q     <= uf_d;
    end
  end

  assign result_o = result_q;
  assign busy_o   = (state_q != StIdle);
  assign done_o   = (state_q == StDone);
  assign dz_o     = dz_q;
  assign uf_o     = uf_q;

endmodule
